// File: rtl/dac_spi_rx_if.sv
// Bundle of serial-link pins and shadow-register outputs for dac_spi_rx.
// The slave modport is the receiver; the master modport drives the link and reads the outputs.
interface dac_spi_rx_if #(
  parameter int DATA_WIDTH = 24,
  parameter int CODE_WIDTH = 16
);
  logic                  sync_i;
  logic                  sclk_i;
  logic                  sdi_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [CODE_WIDTH-1:0] code_o;
  logic [1:0]            pd_o;
  logic                  valid_o;
  logic                  frame_err_o;
  logic                  busy_o;
  logic [7:0]            frame_cnt_o;

  modport slave (
    input  sync_i, sclk_i, sdi_i,
    output data_o, code_o, pd_o, valid_o, frame_err_o, busy_o, frame_cnt_o
  );

  modport master (
    output sync_i, sclk_i, sdi_i,
    input  data_o, code_o, pd_o, valid_o, frame_err_o, busy_o, frame_cnt_o
  );
endinterface

// File: rtl/dac_spi_rx.sv
// SYNC-framed serial receiver: oversamples SYNC/SCLK/SDI in the clk_i domain and
// keeps a DAC-style shadow register of the last complete frame.
module dac_spi_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int CODE_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         arst_i,
  dac_spi_rx_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sync_sr_q, sclk_sr_q, sdi_sr_q;
  logic                   sync_prev_q, sclk_prev_q;
  logic                   sclk_fall_q, sync_fall_q, sync_rise_q, sdi_q;
  logic                   sync_s, sclk_s, sdi_s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  assign sync_s = sync_sr_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sr_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sr_q[SYNC_STAGES-1];

  // SYNC resets low so a frame already running at reset release is never mistaken for idle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_sr_q   <= '0;
      sclk_sr_q   <= '1;
      sdi_sr_q    <= '0;
      sync_prev_q <= 1'b0;
      sclk_prev_q <= 1'b1;
      sclk_fall_q <= 1'b0;
      sync_fall_q <= 1'b0;
      sync_rise_q <= 1'b0;
      sdi_q       <= 1'b0;
    end else begin
      sync_sr_q   <= {sync_sr_q[SYNC_STAGES-2:0], bus.sync_i};
      sclk_sr_q   <= {sclk_sr_q[SYNC_STAGES-2:0], bus.sclk_i};
      sdi_sr_q    <= {sdi_sr_q[SYNC_STAGES-2:0], bus.sdi_i};
      sync_prev_q <= sync_s;
      sclk_prev_q <= sclk_s;
      sclk_fall_q <= sclk_prev_q & ~sclk_s;
      sync_fall_q <= sync_prev_q & ~sync_s;
      sync_rise_q <= ~sync_prev_q & sync_s;
      sdi_q       <= sdi_s;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= WAIT_HIGH;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      WAIT_HIGH: if (sync_s) state_d = IDLE;
      IDLE: begin
        if (sync_fall_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        // The SCLK edge wins over a coincident SYNC rise, so a last-bit/SYNC-rise tie is a good frame.
        if (sclk_fall_q) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sdi_q};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            data_d      = {shift_q[DATA_WIDTH-2:0], sdi_q};
            frame_cnt_d = frame_cnt_q + 8'd1;
            valid_d     = 1'b1;
            state_d     = sync_rise_q ? IDLE : DONE;
          end else if (sync_rise_q) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (sync_rise_q) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DONE: if (sync_rise_q) state_d = IDLE;
      default: state_d = WAIT_HIGH;
    endcase
  end

  assign bus.data_o      = data_q;
  assign bus.code_o      = data_q[CODE_WIDTH-1:0];
  assign bus.pd_o        = data_q[CODE_WIDTH+1:CODE_WIDTH];
  assign bus.valid_o     = valid_q;
  assign bus.frame_err_o = err_q;
  assign bus.busy_o      = (state_q == SHIFT);
  assign bus.frame_cnt_o = frame_cnt_q;
endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: an SPI driver with CLK_DIV=3 timing and a scoreboard of
// expected valid/abort pulses checked whenever the receiver reports a frame.
module tb_dac_spi_rx;
  localparam int DW = 24;
  localparam int CW = 16;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic arst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;

  dac_spi_rx_if #(.DATA_WIDTH(DW), .CODE_WIDTH(CW)) bus ();

  dac_spi_rx #(.DATA_WIDTH(DW), .CODE_WIDTH(CW), .SYNC_STAGES(SS)) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    logic [7:0]    cnt;
    bit            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_data = '0;
  logic [7:0]    m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!arst && (bus.valid_o || bus.frame_err_o)) begin
      exp_t e;
      chk("pulse_exclusive", {31'd0, bus.valid_o & bus.frame_err_o}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, bus.valid_o, bus.frame_err_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_err", {31'd0, bus.frame_err_o}, {31'd0, e.err});
        chk("data_o", {8'd0, bus.data_o}, {8'd0, e.data});
        chk("code_o", {16'd0, bus.code_o}, {16'd0, e.data[15:0]});
        chk("pd_o", {30'd0, bus.pd_o}, {30'd0, e.data[17:16]});
        chk("frame_cnt_o", {24'd0, bus.frame_cnt_o}, {24'd0, e.cnt});
        if (e.lat) chk("valid_latency", cyc - last_fall_cyc, SS + 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_frame(input logic [DW-1:0] w, input bit lat);
    exp_t e;
    m_data = w;
    m_cnt  = m_cnt + 8'd1;
    e.err = 1'b0; e.data = m_data; e.cnt = m_cnt; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic exp_abort();
    exp_t e;
    e.err = 1'b1; e.data = m_data; e.cnt = m_cnt; e.lat = 1'b0;
    sb.push_back(e);
  endtask

  task automatic shift_bits(input logic [DW-1:0] w, input int n, input bit fast_end);
    for (int i = 0; i < n; i++) begin
      bus.sdi_i  = w[DW-1-i];
      bus.sclk_i = 1'b1;
      repeat (3) tick();
      bus.sclk_i = 1'b0;
      if (fast_end && i == n - 1) bus.sync_i = 1'b1;
      last_fall_cyc = cyc;
      repeat (3) tick();
    end
  endtask

  task automatic send(input logic [DW-1:0] w, input int nbits, input logic [3:0] xb,
                      input int nx, input bit fast_end);
    bus.sync_i = 1'b0;
    repeat (3) tick();
    shift_bits(w, nbits, fast_end);
    for (int j = 0; j < nx; j++) begin
      bus.sdi_i  = xb[3-j];
      bus.sclk_i = 1'b1;
      repeat (3) tick();
      bus.sclk_i = 1'b0;
      repeat (3) tick();
    end
    bus.sclk_i = 1'b1;
    repeat (3) tick();
    bus.sync_i = 1'b1;
    repeat (3) tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, {8'd0, bus.data_o}, 32'd0);
    chk({tag, "_code"}, {16'd0, bus.code_o}, 32'd0);
    chk({tag, "_pd"}, {30'd0, bus.pd_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.frame_err_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, bus.frame_cnt_o}, 32'd0);
  endtask

  typedef struct {
    logic [DW-1:0] word;
    int            nbits;
    int            nx;
    logic [3:0]    xbits;
    bit            fast_end;
    bit            lat;
    logic [15:0]   exp_code;
    logic [1:0]    exp_pd;
    logic [7:0]    exp_cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [DW-1:0] w;
    arst = 1'b1;
    bus.sync_i = 1'b1;
    bus.sclk_i = 1'b1;
    bus.sdi_i  = 1'b0;
    repeat (4) tick();
    chk_reset_vals("reset");
    arst = 1'b0;
    repeat (4) tick();

    vecs[0] = '{24'h00A5C3, 24, 0, 4'h0, 1'b0, 1'b1, 16'hA5C3, 2'b00, 8'd1};
    vecs[1] = '{24'h03FFFF, 24, 0, 4'h0, 1'b0, 1'b1, 16'hFFFF, 2'b11, 8'd2};
    vecs[2] = '{24'h000001, 24, 0, 4'h0, 1'b0, 1'b1, 16'h0001, 2'b00, 8'd3};
    vecs[3] = '{24'h001234, 10, 0, 4'h0, 1'b0, 1'b0, 16'h0001, 2'b00, 8'd3};
    vecs[4] = '{24'h001234, 24, 0, 4'h0, 1'b0, 1'b1, 16'h1234, 2'b00, 8'd4};
    vecs[5] = '{24'h00BEEF, 24, 4, 4'hA, 1'b0, 1'b0, 16'hBEEF, 2'b00, 8'd5};
    vecs[6] = '{24'h02C0DE, 24, 0, 4'h0, 1'b1, 1'b1, 16'hC0DE, 2'b10, 8'd6};

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].nbits < DW) exp_abort();
      else exp_frame(vecs[v].word, vecs[v].lat);
      send(vecs[v].word, vecs[v].nbits, vecs[v].xbits, vecs[v].nx, vecs[v].fast_end);
      drain($sformatf("vec%0d", v));
      repeat (5) tick();
      chk($sformatf("vec%0d_code", v), {16'd0, bus.code_o}, {16'd0, vecs[v].exp_code});
      chk($sformatf("vec%0d_pd", v), {30'd0, bus.pd_o}, {30'd0, vecs[v].exp_pd});
      chk($sformatf("vec%0d_cnt", v), {24'd0, bus.frame_cnt_o}, {24'd0, vecs[v].exp_cnt});
    end

    // SYNC low across reset release with SCLK running: nothing may be reported.
    arst = 1'b1;
    bus.sync_i = 1'b0;
    m_data = '0;
    m_cnt  = '0;
    repeat (3) tick();
    arst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.sdi_i = k[0];
      bus.sclk_i = 1'b0; repeat (3) tick();
      bus.sclk_i = 1'b1; repeat (3) tick();
    end
    chk("waithigh_busy", {31'd0, bus.busy_o}, 32'd0);
    bus.sync_i = 1'b1;
    repeat (6) tick();
    exp_frame(24'h000042, 1'b1);
    send(24'h000042, 24, 4'h0, 0, 1'b0);
    drain("waithigh_frame");
    chk("waithigh_code", {16'd0, bus.code_o}, 32'h0042);
    chk("waithigh_cnt", {24'd0, bus.frame_cnt_o}, 32'd1);

    // Reset in the middle of a frame, then 256 frames to wrap the counter.
    bus.sync_i = 1'b0;
    repeat (3) tick();
    shift_bits(24'h00ABCD, 12, 1'b0);
    chk("midframe_busy", {31'd0, bus.busy_o}, 32'd1);
    arst = 1'b1;
    #1;
    chk_reset_vals("midreset");
    m_data = '0;
    m_cnt  = '0;
    repeat (2) tick();
    arst = 1'b0;
    bus.sclk_i = 1'b1;
    repeat (2) tick();
    bus.sync_i = 1'b1;
    repeat (6) tick();
    chk("post_reset_cnt", {24'd0, bus.frame_cnt_o}, 32'd0);
    for (int f = 0; f < 256; f++) begin
      w = DW'($urandom);
      exp_frame(w, 1'b0);
      send(w, 24, 4'h0, 0, 1'b0);
      drain("wrap_frame");
      if (f == 254) chk("cnt_255", {24'd0, bus.frame_cnt_o}, 32'd255);
    end
    chk("wrap_cnt", {24'd0, bus.frame_cnt_o}, 32'd0);
    chk("wrap_code", {16'd0, bus.code_o}, {16'd0, m_data[15:0]});

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dac_spi_rx.md
# dac_spi_rx

Receiving end of the DAC serial link driven by `spi_master_o` in the measure unit: deserialises 24-bit SYNC-framed words into a DAC-style shadow register, exposing the last written 16-bit code and power-down field. Used as an on-chip loopback monitor for threshold-DAC traffic and as the synthesizable DAC model in measure-unit system benches. Inputs are treated as asynchronous and oversampled in the local clock domain.

## Interface
- `DATA_WIDTH`, 24, frame length in bits (MSB first)
- `CODE_WIDTH`, 16, code field width = `data[CODE_WIDTH-1:0]`
- `SYNC_STAGES`, 2, synchroniser flops per serial input (≥2)
- `clk_i` in 1 — sampling clock; one clock, all logic on its rising edge
- `arst_i` in 1 — reset, asynchronous, active-high
- `sync_i` in 1 — frame select, active low
- `sclk_i` in 1 — serial clock, idles high; data sampled on its falling edge
- `sdi_i` in 1 — serial data, MSB first
- `data_o` out DATA_WIDTH — last complete frame
- `code_o` out CODE_WIDTH — `data[15:0]` of last complete frame
- `pd_o` out 2 — `data[17:16]` of last complete frame (power-down mode)
- `valid_o` out 1 — one-cycle pulse, new frame on `data_o`/`code_o`/`pd_o`
- `frame_err_o` out 1 — one-cycle pulse, frame aborted (SYNC high before DATA_WIDTH bits)
- `busy_o` out 1 — high in SHIFT state
- `frame_cnt_o` out 8 — count of valid frames, wraps 255→0

## Operation
- `sync_i`, `sclk_i`, `sdi_i` each pass SYNC_STAGES flops, then one edge-detect flop; edges are detected on synchronised values.
- FSM states: WAIT_HIGH, IDLE, SHIFT, DONE.
  - WAIT_HIGH (reset state): stay until synchronised SYNC = 1 → IDLE. A frame already in progress at reset release is discarded, never reported.
  - IDLE: SYNC falling edge → SHIFT, bit counter ← 0, shift register ← 0.
  - SHIFT: each SCLK falling edge: shift reg ← {shift[DATA_WIDTH-2:0], sdi}, counter+1. On the DATA_WIDTH-th edge → DONE and latch outputs (below). SYNC rising with counter < DATA_WIDTH → IDLE, `frame_err_o` pulse, outputs unchanged.
  - DONE: further SCLK edges ignored; SYNC rising → IDLE, no error.
- Latch on completion: `data_o` ← full word, `code_o` ← word[15:0], `pd_o` ← word[17:16], `frame_cnt_o` +1, `valid_o` pulse. Upper 6 bits of word are don't-care, carried in `data_o` only.
- Same synchronised cycle with final SCLK falling edge and SYNC rising: SCLK edge processed first → frame valid, no error.
- Counter width $clog2(DATA_WIDTH+1); never exceeds DATA_WIDTH.
- SCLK edges while SYNC high (IDLE/WAIT_HIGH) ignored.

## Timing
- Reset values: `data_o`=0, `code_o`=0, `pd_o`=0, `valid_o`=0, `frame_err_o`=0, `busy_o`=0, `frame_cnt_o`=0, FSM=WAIT_HIGH.
- Input constraint: SCLK high and low phases and SDI setup/hold around SCLK fall each ≥ SYNC_STAGES+1 `clk_i` cycles; SYNC low-to-first-fall ≥ 2 cycles. `spi_master_o` with CLK_DIV ≥ 3 on the same clock meets this.
- Latency: pin SCLK fall of last bit → `valid_o` high exactly SYNC_STAGES+2 `clk_i` cycles later; outputs stable from that cycle.
- Pin SYNC rise (abort) → `frame_err_o` SYNC_STAGES+2 cycles later.
- `valid_o`, `frame_err_o` never high together; each exactly one cycle.
- `arst_i` mid-frame: immediate return to reset values; next valid frame needs SYNC high then a new falling edge.

## Test plan
- Reset, then `spi_master_o` (CLK_DIV=3) sends 24'h00_A5C3 → one `valid_o`, `code_o`=16'hA5C3, `pd_o`=0, `frame_cnt_o`=1, no `frame_err_o`.
- Send 24'h03_FFFF then 24'h00_0001 back-to-back → two pulses; final `code_o`=16'h0001, `pd_o`=0; after first frame `pd_o`=2'b11.
- Drop SYNC after 10 bits of 24'h00_1234 → `frame_err_o` one pulse, `code_o` keeps previous value, `frame_cnt_o` unchanged; next full frame 24'h00_1234 accepted.
- 28 SCLK falls in one frame of 24'h00_BEEF + 4 extra bits → `code_o`=16'hBEEF, one `valid_o`, extra bits ignored.
- Hold SYNC low through reset release with SCLK toggling, then raise SYNC and send 24'h00_0042 → no pulse before SYNC high; then `code_o`=16'h0042, `frame_cnt_o`=1.
- Assert `arst_i` after bit 12 of a frame → all outputs at reset values; 256 valid frames afterwards → `frame_cnt_o` wraps to 0.
